lcd_timing_gen: RTL and testbench
=================================

Name: lcd_timing_gen

Overview:
- Parametrised LCD/TFT raster timing generator with a runtime-programmable display window and a fixed-latency pixel-fetch pipeline.
- Sits between the frame-buffer/SDRAM read path and the panel pins. Generates sync, DE and RGB outputs and issues pixel requests ahead of time, so data returned READ_LAT cycles later lines up with DE.
- Window geometry is double-buffered and changes only at frame boundaries.

Parameters:
- H_SYNC, 2, hsync pulse width in clocks
- H_BACK, 44, horizontal back porch
- H_DISP, 800, active pixels per line
- H_FRONT, 210, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 22, vertical back porch
- V_DISP, 480, active lines
- V_FRONT, 22, vertical front porch
- CW, 11, counter/coordinate width (must hold H_TOTAL-1 and V_TOTAL-1)
- DW, 24, pixel width
- READ_LAT, 2, clocks from pixel_req to valid pixel_data (range 0..7)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- win_x  in  CW  window left edge, relative to active area
- win_y  in  CW  window top edge
- win_w  in  CW  window width
- win_h  in  CW  window height
- bg_color  in  DW  colour for active pixels outside the window
- pixel_data  in  DW  fetched pixel, valid READ_LAT cycles after pixel_req
- pixel_req  out  1  pixel fetch strobe
- req_x  out  CW  window-relative x of the request (0 when idle)
- req_y  out  CW  window-relative y of the request (0 when idle)
- frame_start  out  1  one-cycle pulse at h=0, v=0 (undelayed)
- line_start  out  1  one-cycle pulse at every h=0 (undelayed)
- lcd_clk  out  1  equals clk
- lcd_de  out  1  data enable
- lcd_hsync  out  1  horizontal sync
- lcd_vsync  out  1  vertical sync
- lcd_rgb  out  DW  pixel output

Behaviour:
- Derived constants: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL likewise. HA0 = H_SYNC+H_BACK; VA0 = V_SYNC+V_BACK.
- Horizontal counter h counts 0..H_TOTAL-1, then wraps to 0.
- Vertical counter v increments when h = H_TOTAL-1 and wraps after V_TOTAL-1. Exactly H_TOTAL x V_TOTAL clocks per frame.
- Stage-0 decode, from h and v in the current cycle:
  - hs_act = (h < H_SYNC); vs_act = (v < V_SYNC).
  - active = (HA0 <= h < HA0+H_DISP) and (VA0 <= v < VA0+V_DISP).
  - ax = h-HA0; ay = v-VA0.
  - inwin = active and (ax - sx) < sw and (ay - sy) < sh, using unsigned CW-bit compares after subtraction, with sx, sy, sw, sh from the shadow registers.
- Window shadow registers:
  - Loaded from win_* on the cycle h = H_TOTAL-1, v = V_TOTAL-1, so new values take effect at frame_start.
  - Reset values: sx=0, sy=0, sw=H_DISP, sh=V_DISP.
  - win_w=0 or win_h=0 disables all requests; the whole active area shows bg_color.
  - The window is clipped to the active area; no request is ever issued outside it.
- pixel_req = inwin (stage-0 combinational). req_x = ax-sx and req_y = ay-sy when inwin, else 0.
- frame_start and line_start are stage-0 combinational.
- Output pipeline:
  - hs_act, vs_act, active and inwin are delayed READ_LAT+1 register stages.
  - lcd_hsync = delayed hs_act XNOR HS_POL; lcd_vsync is formed the same way with VS_POL.
  - lcd_de = delayed active.
  - lcd_rgb is registered:
    - pixel_data when delayed inwin = 1,
    - else bg_color when delayed active = 1,
    - else 0.
  - Result: every lcd_* output is exactly READ_LAT+1 clocks behind its stage-0 decode.
- Reset (asynchronous, any time, including mid-frame):
  - h=0, v=0, all pipeline stages cleared.
  - lcd_de=0, lcd_rgb=0, pixel_req=0, req_x=0, req_y=0.
  - lcd_hsync and lcd_vsync at their inactive level (~HS_POL, ~VS_POL).
  - Shadow registers return to their reset values.
  - After rst_n deasserts, the first frame starts at h=0, v=0. frame_start is high in the first cycle after reset release.
- Requests must not depend on pixel_data. No back-pressure: the consumer must honour READ_LAT.

Test Plan:
- Small timing (H 2/3/8/2 → H_TOTAL=15; V 1/2/4/1 → V_TOTAL=8), READ_LAT=2, reset window → 120 clocks per frame; frame_start every 120 clocks; 32 pixel_req per frame; lcd_de high for 8 consecutive clocks starting 3 clocks after each line's first pixel_req.
- Same config, window x=2 y=1 w=3 h=2, applied mid-frame → no change until the next frame_start. Then 6 requests per frame with req_x 0..2 and req_y 0..1. lcd_rgb = bg_color for active pixels ax∈{0,1,5,6,7}.
- Echo model returns pixel_data = {req_y,req_x} delayed 2 → each lcd_rgb window pixel equals its own coordinates; no off-by-one at the window edges.
- HS_POL=1, VS_POL=0 → hsync high for 2 clocks per line; vsync low for 15 clocks per frame. During reset, hsync=0 and vsync=1.
- win_w=0 → zero pixel_req over a full frame; lcd_rgb = bg_color whenever lcd_de=1.
- Assert rst_n low at v=3, h=7 → all outputs at reset values immediately. After release, the next frame is exactly 120 clocks long.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// LCD/TFT raster timing generator: free-running h/v counters, frame-latched display window,
// and a fixed-latency output pipeline that lines fetched pixel data up with DE.
module lcd_timing_gen #(
    parameter int unsigned H_SYNC   = 2,
    parameter int unsigned H_BACK   = 44,
    parameter int unsigned H_DISP   = 800,
    parameter int unsigned H_FRONT  = 210,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 22,
    parameter int unsigned V_DISP   = 480,
    parameter int unsigned V_FRONT  = 22,
    parameter int unsigned CW       = 11,
    parameter int unsigned DW       = 24,
    parameter int unsigned READ_LAT = 2,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] win_x,
    input  logic [CW-1:0] win_y,
    input  logic [CW-1:0] win_w,
    input  logic [CW-1:0] win_h,
    input  logic [DW-1:0] bg_color,
    input  logic [DW-1:0] pixel_data,
    output logic          pixel_req,
    output logic [CW-1:0] req_x,
    output logic [CW-1:0] req_y,
    output logic          frame_start,
    output logic          line_start,
    output logic          lcd_clk,
    output logic          lcd_de,
    output logic          lcd_hsync,
    output logic          lcd_vsync,
    output logic [DW-1:0] lcd_rgb
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [CW-1:0] HLast    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] VLast    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HSyncEnd = CW'(H_SYNC);
    localparam logic [CW-1:0] VSyncEnd = CW'(V_SYNC);
    localparam logic [CW-1:0] HA0      = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] HA1      = CW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CW-1:0] VA0      = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] VA1      = CW'(V_SYNC + V_BACK + V_DISP);

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          frame_end;

    logic [CW-1:0] sx_q, sy_q, sw_q, sh_q;

    logic          hs_act, vs_act, h_act, v_act, active, inwin;
    logic [CW-1:0] ax, ay, rel_x, rel_y;

    // Bit i of each pipe holds the stage-0 value delayed by i+1 clocks.
    logic [READ_LAT:0]   hs_pipe_q, vs_pipe_q, act_pipe_q, win_pipe_q;
    logic [READ_LAT+1:0] hs_tap, vs_tap, act_tap, win_tap;
    logic [DW-1:0]       rgb_q, rgb_d;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_comb begin
        h_d = h_q + CW'(1);
        v_d = v_q;
        if (h_q == HLast) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + CW'(1);
        end
    end

    assign frame_end = (h_q == HLast) && (v_q == VLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // ------------------------------------------------------------------
    // Window shadow registers, swapped only on the last clock of a frame
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q <= '0;
            sy_q <= '0;
            sw_q <= CW'(H_DISP);
            sh_q <= CW'(V_DISP);
        end else if (frame_end) begin
            sx_q <= win_x;
            sy_q <= win_y;
            sw_q <= win_w;
            sh_q <= win_h;
        end
    end

    // ------------------------------------------------------------------
    // Stage-0 decode
    // ------------------------------------------------------------------
    always_comb begin
        hs_act = (h_q < HSyncEnd);
        vs_act = (v_q < VSyncEnd);
        h_act  = (h_q >= HA0) && (h_q < HA1);
        v_act  = (v_q >= VA0) && (v_q < VA1);
        active = h_act && v_act;
        ax     = h_q - HA0;
        ay     = v_q - VA0;
        rel_x  = ax - sx_q;
        rel_y  = ay - sy_q;
        // Wrapped subtraction makes pixels left/above the window look huge, so one compare
        // per axis covers both edges; gating with active clips to the display area.
        inwin  = active && (rel_x < sw_q) && (rel_y < sh_q);
    end

    assign pixel_req   = inwin;
    assign req_x       = inwin ? rel_x : '0;
    assign req_y       = inwin ? rel_y : '0;
    assign frame_start = (h_q == '0) && (v_q == '0);
    assign line_start  = (h_q == '0);
    assign lcd_clk     = clk;

    // ------------------------------------------------------------------
    // Output alignment pipeline
    // ------------------------------------------------------------------
    assign hs_tap  = {hs_pipe_q, hs_act};
    assign vs_tap  = {vs_pipe_q, vs_act};
    assign act_tap = {act_pipe_q, active};
    assign win_tap = {win_pipe_q, inwin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_pipe_q  <= '0;
            vs_pipe_q  <= '0;
            act_pipe_q <= '0;
            win_pipe_q <= '0;
        end else begin
            hs_pipe_q  <= hs_tap[READ_LAT:0];
            vs_pipe_q  <= vs_tap[READ_LAT:0];
            act_pipe_q <= act_tap[READ_LAT:0];
            win_pipe_q <= win_tap[READ_LAT:0];
        end
    end

    // Select with READ_LAT-delayed flags; the rgb register adds the final clock.
    always_comb begin
        rgb_d = '0;
        if (win_tap[READ_LAT]) begin
            rgb_d = pixel_data;
        end else if (act_tap[READ_LAT]) begin
            rgb_d = bg_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign lcd_de    = act_pipe_q[READ_LAT];
    assign lcd_hsync = ~(hs_pipe_q[READ_LAT] ^ HS_POL);
    assign lcd_vsync = ~(vs_pipe_q[READ_LAT] ^ VS_POL);
    assign lcd_rgb   = rgb_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a small 15x8 raster with an echo pixel source.
module tb_lcd_timing_gen;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] win_x, win_y, win_w, win_h;
    logic [DW-1:0] bg_color;
    logic [DW-1:0] pixel_data;
    logic          pixel_req;
    logic [CW-1:0] req_x, req_y;
    logic          frame_start, line_start, lcd_clk, lcd_de, lcd_hsync, lcd_vsync;
    logic [DW-1:0] lcd_rgb;

    int checks = 0;
    int errors = 0;
    int cyc;
    int sx, sy, sw, sh;
    int n_req, n_de, n_hs, n_vsl, n_fs;

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
        .CW(CW), .DW(DW), .READ_LAT(2), .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
        .bg_color(bg_color), .pixel_data(pixel_data),
        .pixel_req(pixel_req), .req_x(req_x), .req_y(req_y),
        .frame_start(frame_start), .line_start(line_start), .lcd_clk(lcd_clk),
        .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_rgb(lcd_rgb)
    );

    // Echo memory: tags each returned word with its own coordinates, garbage when idle.
    logic [DW-1:0] echo1 = '1;
    logic [DW-1:0] echo2 = '1;
    always @(posedge clk) begin
        echo1 <= pixel_req ? {8'h5A, req_y, req_x} : 24'hFFFFFF;
        echo2 <= echo1;
    end
    assign pixel_data = echo2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cyc %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference decode of frame position p (0..119) against the modelled shadow window.
    task automatic decode(input int p, output bit hs, output bit vs, output bit act,
                          output bit inw, output int rx, output int ry);
        int h, v;
        h   = p % 15;
        v   = p / 15;
        hs  = (h < 2);
        vs  = (v < 1);
        act = (h >= 5) && (h < 13) && (v >= 3) && (v < 7);
        rx  = h - 5 - sx;
        ry  = v - 3 - sy;
        inw = act && (rx >= 0) && (rx < sw) && (ry >= 0) && (ry < sh);
    endtask

    task automatic check_cycle();
        int p, rx, ry;
        bit hs, vs, act, inw;
        logic [DW-1:0] exp_rgb;
        p = cyc % 120;
        decode(p, hs, vs, act, inw, rx, ry);
        chk("pixel_req", 32'(pixel_req), 32'(inw));
        chk("req_x", 32'(req_x), inw ? 32'(rx) : 32'd0);
        chk("req_y", 32'(req_y), inw ? 32'(ry) : 32'd0);
        chk("frame_start", 32'(frame_start), 32'(p == 0));
        chk("line_start", 32'(line_start), 32'(p % 15 == 0));
        if (p < 3) begin
            hs = 1'b0; vs = 1'b0; act = 1'b0; inw = 1'b0;
        end else begin
            decode(p - 3, hs, vs, act, inw, rx, ry);
        end
        exp_rgb = inw ? {8'h5A, 8'(ry), 8'(rx)} : (act ? bg_color : '0);
        chk("lcd_hsync", 32'(lcd_hsync), 32'(hs));
        chk("lcd_vsync", 32'(lcd_vsync), 32'(!vs));
        chk("lcd_de", 32'(lcd_de), 32'(act));
        chk("lcd_rgb", 32'(lcd_rgb), 32'(exp_rgb));
        n_req += int'(pixel_req);
        n_de  += int'(lcd_de);
        n_hs  += int'(lcd_hsync);
        n_vsl += int'(!lcd_vsync);
        n_fs  += int'(frame_start);
    endtask

    task automatic step();
        if (cyc % 120 == 119) begin
            sx = int'(win_x); sy = int'(win_y); sw = int'(win_w); sh = int'(win_h);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            check_cycle();
            step();
        end
    endtask

    task automatic clear_counts();
        n_req = 0; n_de = 0; n_hs = 0; n_vsl = 0; n_fs = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " pixel_req"}, 32'(pixel_req), 32'd0);
        chk({tag, " req_x"}, 32'(req_x), 32'd0);
        chk({tag, " req_y"}, 32'(req_y), 32'd0);
        chk({tag, " lcd_de"}, 32'(lcd_de), 32'd0);
        chk({tag, " lcd_rgb"}, 32'(lcd_rgb), 32'd0);
        chk({tag, " lcd_hsync"}, 32'(lcd_hsync), 32'd0);
        chk({tag, " lcd_vsync"}, 32'(lcd_vsync), 32'd1);
    endtask

    task automatic reset_model();
        cyc = 0; sx = 0; sy = 0; sw = 8; sh = 4;
    endtask

    initial begin
        rst_n = 1'b0;
        win_x = 8'd0; win_y = 8'd0; win_w = 8'd8; win_h = 8'd4;
        bg_color = 24'h112233;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");

        // Frame 0: full-screen window.
        rst_n = 1'b1;
        clear_counts();
        run(120);
        chk("f0 req count", 32'(n_req), 32'd32);
        chk("f0 de count", 32'(n_de), 32'd32);
        chk("f0 hsync high", 32'(n_hs), 32'd16);
        chk("f0 vsync low", 32'(n_vsl), 32'd15);
        chk("f0 frame_start", 32'(n_fs), 32'd1);

        // Frame 1: window written mid-frame must not take effect yet.
        clear_counts();
        run(60);
        win_x = 8'd2; win_y = 8'd1; win_w = 8'd3; win_h = 8'd2;
        run(60);
        chk("f1 req count", 32'(n_req), 32'd32);

        // Frame 2: 3x2 window at (2,1).
        clear_counts();
        run(120);
        chk("f2 req count", 32'(n_req), 32'd6);
        chk("f2 de count", 32'(n_de), 32'd32);

        // Frame 3: zero width queued, old window still live.
        win_w = 8'd0;
        clear_counts();
        run(120);
        chk("f3 req count", 32'(n_req), 32'd6);

        // Frame 4: zero width live, everything background.
        bg_color = 24'h445566;
        clear_counts();
        run(120);
        chk("f4 req count", 32'(n_req), 32'd0);
        chk("f4 de count", 32'(n_de), 32'd32);

        // Frame 5: reset asserted asynchronously at v=3, h=7.
        win_w = 8'd3;
        clear_counts();
        run(52);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held");
        rst_n = 1'b1;
        reset_model();
        clear_counts();
        run(120);
        chk("post-reset req count", 32'(n_req), 32'd32);
        chk("post-reset frame_start", 32'(n_fs), 32'd1);
        run(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
